// File: rtl/mimc_pow7_round_pkg.sv
// mimc_pkg: shared constants and FSM state type for the MiMC x^7 round.
package mimc_pkg;
    localparam int N_BITS = 254;
    localparam int MULT_LATENCY = 3;
    localparam logic [N_BITS-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [N_BITS:0] P2 = {P, 1'b0};
    typedef enum logic [2:0] {IDLE, ADD, MUL, KADD, DONE} state_e;
endpackage

// File: rtl/mimc_pow7_round_if.sv
// mimc_pow7_round_if: request/result bundle between a round client and the round engine.
interface mimc_pow7_round_if #(parameter int N_BITS = mimc_pkg::N_BITS);
    logic start;
    logic busy;
    logic done;
    logic [N_BITS-1:0] x_in;
    logic [N_BITS-1:0] k_in;
    logic [N_BITS-1:0] c_in;
    logic [N_BITS-1:0] y_out;
    modport master (output start, x_in, k_in, c_in, input busy, done, y_out);
    modport slave (input start, x_in, k_in, c_in, output busy, done, y_out);
endinterface

// File: rtl/mimc_pow7_round_mult.sv
// galois_mult_barrett_sync: (num1*num2) mod P via Barrett reduction, product valid MULT_LATENCY cycles after stable operands.
module galois_mult_barrett_sync #(
    parameter int N_BITS = mimc_pkg::N_BITS,
    parameter int MULT_LATENCY = mimc_pkg::MULT_LATENCY
) (
    input logic clk,
    input logic [N_BITS-1:0] num1,
    input logic [N_BITS-1:0] num2,
    output logic [N_BITS-1:0] product,
    output logic ready
);
    import mimc_pkg::*;
    localparam int W = 2 * N_BITS + 4;
    localparam int CW = MULT_LATENCY > 1 ? $clog2(MULT_LATENCY) : 1;
    localparam logic [W-1:0] PW = W'(P);
    localparam logic [W-1:0] MU = (W'(1) << (2 * N_BITS)) / PW;
    logic [W-1:0] prod_w, q_w, r_w;
    logic [N_BITS-1:0] red, n1_q, n2_q;
    logic [CW-1:0] cnt_q;
    logic same;
    // Barrett estimate undershoots by at most 2P, so two conditional subtracts finish the reduction
    assign prod_w = W'(num1) * W'(num2);
    assign q_w = ((prod_w >> (N_BITS - 1)) * MU) >> (N_BITS + 1);
    assign r_w = prod_w - q_w * PW;
    assign red = N_BITS'(r_w >= (PW << 1) ? r_w - (PW << 1) : r_w >= PW ? r_w - PW : r_w);
    if (MULT_LATENCY > 1) begin : g_pipe
        logic [N_BITS-1:0] pipe_q [MULT_LATENCY-1];
        always_ff @(posedge clk) begin
            pipe_q[0] <= red;
            for (int i = 1; i < MULT_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
        assign product = pipe_q[MULT_LATENCY-2];
    end else begin : g_comb
        assign product = red;
    end
    assign same = num1 == n1_q && num2 == n2_q;
    always_ff @(posedge clk) begin
        n1_q <= num1;
        n2_q <= num2;
        cnt_q <= !same ? '0 : int'(cnt_q) + 2 >= MULT_LATENCY ? cnt_q : cnt_q + 1'b1;
    end
    assign ready = MULT_LATENCY == 1 || (same && int'(cnt_q) + 2 >= MULT_LATENCY);
endmodule

// File: rtl/mimc_pow7_round.sv
// mimc_pow7_round: one MiMC round y = (x + k + c)^7 mod P over a single shared modular multiplier.
// Define MIMC_KEY_ADD_OUT_EN to add the key to the output in an extra KADD cycle.
module mimc_pow7_round #(
    parameter int N_BITS = mimc_pkg::N_BITS,
    parameter int MULT_LATENCY = mimc_pkg::MULT_LATENCY
) (
    input logic clk,
    input logic rst,
    mimc_pow7_round_if.slave bus
);
    import mimc_pkg::*;
    localparam int LW = MULT_LATENCY > 1 ? $clog2(MULT_LATENCY) : 1;
    localparam logic [N_BITS+1:0] PW = (N_BITS+2)'(P);
    localparam logic [N_BITS+1:0] P2W = (N_BITS+2)'(P2);
    state_e state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [N_BITS-1:0] x_q, x_d, k_q, k_d, c_q, c_d, t_q, t_d;
    logic [N_BITS-1:0] r2_q, r2_d, r3_q, r3_d, r6_q, r6_d, y_q, y_d;
    logic [N_BITS-1:0] num1, num2, prod, t_red;
    logic [N_BITS+1:0] s;
    logic lat_last;
    assign s = {2'b0, x_q} + {2'b0, k_q} + {2'b0, c_q};
    assign t_red = N_BITS'(s >= P2W ? s - P2W : s >= PW ? s - PW : s);
    assign lat_last = lat_q == LW'(MULT_LATENCY - 1);
    // chain t^2, t^3, t^6, t^7 through the one multiplier
    assign num1 = step_q == 2'd0 ? t_q : step_q == 2'd1 ? r2_q : step_q == 2'd2 ? r3_q : r6_q;
    assign num2 = step_q == 2'd2 ? r3_q : t_q;
    galois_mult_barrett_sync #(.N_BITS(N_BITS), .MULT_LATENCY(MULT_LATENCY)) u_mult (
        .clk(clk),
        .num1(num1),
        .num2(num2),
        .product(prod),
        .ready()
    );
`ifdef MIMC_KEY_ADD_OUT_EN
    logic [N_BITS:0] ks;
    logic [N_BITS-1:0] ky;
    assign ks = {1'b0, r6_q} + {1'b0, k_q};
    assign ky = N_BITS'(ks >= (N_BITS+1)'(P) ? ks - (N_BITS+1)'(P) : ks);
`endif
    always_comb begin
        state_d = state_q;
        step_d = step_q;
        lat_d = lat_q;
        x_d = x_q;
        k_d = k_q;
        c_d = c_q;
        t_d = t_q;
        r2_d = r2_q;
        r3_d = r3_q;
        r6_d = r6_q;
        y_d = y_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? ADD : IDLE;
                x_d = bus.start ? bus.x_in : x_q;
                k_d = bus.start ? bus.k_in : k_q;
                c_d = bus.start ? bus.c_in : c_q;
            end
            ADD: begin
                state_d = MUL;
                t_d = t_red;
                step_d = '0;
                lat_d = '0;
            end
            MUL: begin
                lat_d = lat_last ? '0 : lat_q + 1'b1;
                step_d = lat_last ? step_q + 1'b1 : step_q;
                r2_d = lat_last && step_q == 2'd0 ? prod : r2_q;
                r3_d = lat_last && step_q == 2'd1 ? prod : r3_q;
`ifdef MIMC_KEY_ADD_OUT_EN
                r6_d = lat_last && step_q[1] ? prod : r6_q;
                state_d = lat_last && step_q == 2'd3 ? KADD : MUL;
            end
            KADD: begin
                y_d = ky;
                state_d = DONE;
            end
`else
                r6_d = lat_last && step_q == 2'd2 ? prod : r6_q;
                y_d = lat_last && step_q == 2'd3 ? prod : y_q;
                state_d = lat_last && step_q == 2'd3 ? DONE : MUL;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q <= '0;
            lat_q <= '0;
            x_q <= '0;
            k_q <= '0;
            c_q <= '0;
            t_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            r6_q <= '0;
            y_q <= '0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            lat_q <= lat_d;
            x_q <= x_d;
            k_q <= k_d;
            c_q <= c_d;
            t_q <= t_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
            r6_q <= r6_d;
            y_q <= y_d;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.y_out = y_q;
endmodule

// File: tb/tb_mimc_pow7_round.sv
// tb_mimc_pow7_round: vector table, corner sequences and random rounds against a modular-arithmetic model.
module tb_mimc_pow7_round;
    localparam int NB = 254;
    localparam int ML = 3;
`ifdef MIMC_KEY_ADD_OUT_EN
    localparam int KADD = 1;
`else
    localparam int KADD = 0;
`endif
    localparam int LAT = 1 + 4 * ML + KADD;
    localparam logic [NB-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [511:0] P512 = {258'd0, P};
    typedef logic [NB-1:0] fe_t;
    typedef struct { fe_t x; fe_t k; fe_t c; fe_t y7; } vec_t;

    logic clk = 0;
    logic rst = 1;
    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl [9];

    mimc_pow7_round_if #(.N_BITS(NB)) bus ();
    mimc_pow7_round #(.N_BITS(NB), .MULT_LATENCY(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic fe_t mulmod(fe_t a, fe_t b);
        logic [511:0] w = {258'd0, a} * {258'd0, b};
        return NB'(w % P512);
    endfunction

    function automatic fe_t addmod(fe_t a, fe_t b);
        return NB'(({258'd0, a} + {258'd0, b}) % P512);
    endfunction

    function automatic fe_t pow7(fe_t x, fe_t k, fe_t c);
        fe_t t = addmod(addmod(x, k), c);
        fe_t y = 1;
        for (int i = 0; i < 7; i++) y = mulmod(y, t);
        return y;
    endfunction

    function automatic fe_t exp_out(fe_t y7, fe_t k);
        return KADD != 0 ? addmod(y7, k) : y7;
    endfunction

    function automatic fe_t rnd_fe();
        logic [511:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[479:0], 32'($urandom)};
        return NB'(r % P512);
    endfunction

    task automatic chk(input string nm, input fe_t act, input fe_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_round(input fe_t x, input fe_t k, input fe_t c, input fe_t y7, input string nm);
        int n;
        logic busy_ok;
        @(negedge clk);
        bus.x_in = x;
        bus.k_in = k;
        bus.c_in = c;
        bus.start = 1;
        @(posedge clk);
        #1;
        bus.start = 0;
        bus.x_in = rnd_fe();
        bus.k_in = rnd_fe();
        bus.c_in = rnd_fe();
        n = 0;
        busy_ok = 1;
        while (!bus.done && n < 40) begin
            busy_ok = busy_ok & bus.busy;
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, NB'(n), NB'(LAT));
        chk({nm, " y_out"}, bus.y_out, exp_out(y7, k));
        chk({nm, " busy"}, NB'(busy_ok & bus.busy), NB'(1));
        @(posedge clk);
        #1;
        chk({nm, " done pulse"}, NB'(bus.done), NB'(0));
        chk({nm, " idle"}, NB'(bus.busy), NB'(0));
    endtask

    initial begin
        int n, dones, first, second;
        fe_t x, k, c, y_seen;
        bus.start = 0;
        bus.x_in = '0;
        bus.k_in = '0;
        bus.c_in = '0;
        tbl[0] = '{x: 0, k: 0, c: 0, y7: 0};
        tbl[1] = '{x: 1, k: 0, c: 1, y7: 128};
        tbl[2] = '{x: P - 1, k: 1, c: 0, y7: 0};
        tbl[3] = '{x: P - 1, k: P - 1, c: P - 1, y7: P - 2187};
        tbl[4] = '{x: 3, k: 0, c: 0, y7: 2187};
        tbl[5] = '{x: P - 1, k: 0, c: 0, y7: P - 1};
        tbl[6] = '{x: 1, k: 1, c: 1, y7: 2187};
        tbl[7] = '{x: 0, k: P - 2, c: 0, y7: P - 128};
        tbl[8] = '{x: 1, k: 1, c: 0, y7: 128};

        #12;
        chk("reset busy", NB'(bus.busy), NB'(0));
        chk("reset done", NB'(bus.done), NB'(0));
        chk("reset y_out", bus.y_out, NB'(0));
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) run_round(tbl[i].x, tbl[i].k, tbl[i].c, tbl[i].y7, $sformatf("vec%0d", i));

        // starts at cycles 3 and 12 of a round must be ignored
        @(negedge clk);
        bus.x_in = 5;
        bus.k_in = 0;
        bus.c_in = 0;
        bus.start = 1;
        @(posedge clk);
        #1;
        bus.start = 0;
        n = 0;
        dones = 0;
        first = -1;
        y_seen = '0;
        while (n < 30) begin
            bus.start = (n == 2 || n == 11);
            if (bus.start) begin
                bus.x_in = 1;
                bus.k_in = 0;
                bus.c_in = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (bus.done) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    y_seen = bus.y_out;
                end
            end
        end
        bus.start = 0;
        chk("busy-start done count", NB'(dones), NB'(1));
        chk("busy-start latency", NB'(first), NB'(LAT));
        chk("busy-start y_out", y_seen, exp_out(NB'(78125), 0));

        // start held high: ignored in DONE, taken in the following IDLE cycle
        @(negedge clk);
        bus.x_in = 1;
        bus.k_in = 0;
        bus.c_in = 2;
        bus.start = 1;
        @(posedge clk);
        #1;
        n = 0;
        first = -1;
        second = -1;
        while (second < 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) begin
                if (first < 0) first = n;
                else second = n;
                chk("b2b y_out", bus.y_out, exp_out(NB'(2187), 0));
            end
        end
        bus.start = 0;
        chk("b2b first latency", NB'(first), NB'(LAT));
        chk("b2b gap", NB'(second - first), NB'(LAT + 2));
        @(posedge clk);
        #1;
        chk("b2b idle", NB'(bus.busy), NB'(0));

        // asynchronous reset in the middle of a round
        @(negedge clk);
        bus.x_in = P - 1;
        bus.k_in = P - 1;
        bus.c_in = P - 1;
        bus.start = 1;
        @(posedge clk);
        #1;
        bus.start = 0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("rst busy", NB'(bus.busy), NB'(0));
        chk("rst done", NB'(bus.done), NB'(0));
        chk("rst y_out", bus.y_out, NB'(0));
        @(negedge clk);
        rst = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            dones += int'(bus.done);
        end
        chk("rst no done", NB'(dones), NB'(0));
        run_round(1, 0, 1, 128, "after rst");

        for (int i = 0; i < 20; i++) begin
            x = rnd_fe();
            k = rnd_fe();
            c = rnd_fe();
            run_round(x, k, c, pow7(x, k, c), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
